// File: rtl/brtag_manager.sv
// rtl/brtag_manager.sv - one-hot speculative branch tag allocator and resolver; BRTAG_STATS_EN adds resolution counters
module brtag_manager #(
    parameter int SPECTAG_LEN = 5,
    parameter int ADDR_LEN    = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               alloc_req,
    output logic                               alloc_gnt,
    output logic [SPECTAG_LEN-1:0]             alloc_tag,
    input  logic                               prsuccess,
    input  logic                               prmiss,
    input  logic [SPECTAG_LEN-1:0]             spectag,
    input  logic [SPECTAG_LEN-1:0]             tagregfix,
    input  logic [ADDR_LEN-1:0]                jmpaddr,
    output logic [SPECTAG_LEN-1:0]             busy_vec,
    output logic                               full,
    output logic [$clog2(SPECTAG_LEN+1)-1:0]   count,
    output logic                               kill_valid,
    output logic [SPECTAG_LEN-1:0]             kill_mask,
    output logic                               redirect_valid,
    output logic [ADDR_LEN-1:0]                redirect_pc,
    output logic [SPECTAG_LEN-1:0]             free_mask
`ifdef BRTAG_STATS_EN
    ,
    output logic [31:0]                        stat_succ,
    output logic [31:0]                        stat_miss
`endif
);

    localparam int CNT_W = $clog2(SPECTAG_LEN + 1);

    logic [SPECTAG_LEN-1:0] tagreg;
    logic [SPECTAG_LEN-1:0] younger;
    logic [SPECTAG_LEN-1:0] walk;
    logic                   walking;
    logic                   spec_onehot;
    logic                   accept;
    logic                   miss_acc;
    logic                   succ_acc;

    // The ring is full once the next tag to hand out is still outstanding.
    assign full      = |(busy_vec & tagreg);
    assign alloc_gnt = alloc_req & ~full & ~prmiss;
    assign alloc_tag = tagreg;

    // Resolutions naming a malformed or idle tag are dropped without side effects.
    assign spec_onehot = (spectag != '0) && ((spectag & (spectag - SPECTAG_LEN'(1))) == '0);
    assign accept      = spec_onehot & (|(busy_vec & spectag));
    assign miss_acc    = prmiss & accept;
    assign succ_acc    = prsuccess & ~prmiss & accept;

    // Walk the ring in allocation order from the tag after the missed branch up to the allocation pointer.
    always_comb begin
        younger = '0;
        walk    = tagregfix;
        walking = 1'b1;
        for (int i = 0; i < SPECTAG_LEN; i++) begin
            if (walk == tagreg) begin
                walking = 1'b0;
            end
            if (walking) begin
                younger = younger | (walk & busy_vec);
            end
            walk = {walk[0], walk[SPECTAG_LEN-1:1]};
        end
    end

    // Outstanding-tag population count.
    always_comb begin
        count = '0;
        for (int i = 0; i < SPECTAG_LEN; i++) begin
            count = count + CNT_W'(busy_vec[i]);
        end
    end

    // Tag ring state plus the one-cycle kill/redirect/free pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tagreg         <= SPECTAG_LEN'(1);
            busy_vec       <= '0;
            kill_valid     <= 1'b0;
            kill_mask      <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            free_mask      <= '0;
        end else begin
            if (miss_acc) begin
                busy_vec <= busy_vec & ~(spectag | younger);
                tagreg   <= tagregfix;
            end else begin
                busy_vec <= (busy_vec & ~(succ_acc ? spectag : '0)) | (alloc_gnt ? tagreg : '0);
                if (alloc_gnt) begin
                    tagreg <= {tagreg[0], tagreg[SPECTAG_LEN-1:1]};
                end
            end
            kill_valid     <= miss_acc;
            redirect_valid <= miss_acc;
            kill_mask      <= miss_acc ? younger : '0;
            if (miss_acc) begin
                redirect_pc <= jmpaddr;
            end
            free_mask <= (miss_acc | succ_acc) ? spectag : '0;
        end
    end

`ifdef BRTAG_STATS_EN
    // Saturating counts of accepted resolutions.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_succ <= '0;
            stat_miss <= '0;
        end else begin
            if (succ_acc && stat_succ != 32'hFFFF_FFFF) begin
                stat_succ <= stat_succ + 32'd1;
            end
            if (miss_acc && stat_miss != 32'hFFFF_FFFF) begin
                stat_miss <= stat_miss + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_brtag_manager.sv
// tb/tb_brtag_manager.sv - scoreboard bench for brtag_manager against an allocation-order queue model
module tb_brtag_manager;

    localparam int N  = 5;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          alloc_req;
    logic          alloc_gnt;
    logic [N-1:0]  alloc_tag;
    logic          prsuccess;
    logic          prmiss;
    logic [N-1:0]  spectag;
    logic [N-1:0]  tagregfix;
    logic [AW-1:0] jmpaddr;
    logic [N-1:0]  busy_vec;
    logic          full;
    logic [2:0]    count;
    logic          kill_valid;
    logic [N-1:0]  kill_mask;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic [N-1:0]  free_mask;
`ifdef BRTAG_STATS_EN
    logic [31:0]   stat_succ;
    logic [31:0]   stat_miss;
`endif

    brtag_manager #(.SPECTAG_LEN(N), .ADDR_LEN(AW)) dut (
        .clk(clk), .reset(reset),
        .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
        .prsuccess(prsuccess), .prmiss(prmiss), .spectag(spectag),
        .tagregfix(tagregfix), .jmpaddr(jmpaddr),
        .busy_vec(busy_vec), .full(full), .count(count),
        .kill_valid(kill_valid), .kill_mask(kill_mask),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .free_mask(free_mask)
`ifdef BRTAG_STATS_EN
        , .stat_succ(stat_succ), .stat_miss(stat_miss)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  busy;
        logic          full;
        logic [2:0]    count;
        logic          gnt;
        logic [N-1:0]  tag;
        logic [AW-1:0] pc;
    } rec_t;

    typedef struct {
        logic [N-1:0]  mask;
        logic [AW-1:0] pc;
    } kill_t;

    rec_t         st_q[$];
    kill_t        kill_q[$];
    logic [N-1:0] tag_q[$];
    logic [N-1:0] free_q[$];

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // Reference model: outstanding tag indices in allocation order, allocation pointer index, last redirect.
    int            outq[$];
    int            ptr = 0;
    logic [AW-1:0] mpc = '0;
    int            n_succ = 0;
    int            n_miss = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [N-1:0] model_busy();
        logic [N-1:0] b = '0;
        foreach (outq[j]) b[outq[j]] = 1'b1;
        return b;
    endfunction

    task automatic cycle(input logic req, input logic succ, input logic miss,
                         input logic [N-1:0] stag, input logic [AW-1:0] pc);
        rec_t         r;
        logic [N-1:0] busy;
        logic [N-1:0] yng;
        logic         g;
        logic         acc;
        int           s;
        int           k;
        @(posedge clk);
        #1;
        busy    = model_busy();
        g       = req && !busy[ptr] && !miss;
        r.busy  = busy;
        r.full  = busy[ptr];
        r.count = 3'(outq.size());
        r.gnt   = g;
        r.tag   = N'(1) << ptr;
        r.pc    = mpc;
        st_q.push_back(r);
        alloc_req = req;
        prsuccess = succ;
        prmiss    = miss;
        spectag   = stag;
        tagregfix = {stag[0], stag[N-1:1]};
        jmpaddr   = pc;
        if (g) tag_q.push_back(N'(1) << ptr);
        acc = ($countones(stag) == 1) && ((busy & stag) != '0);
        s = 0;
        k = -1;
        if (acc) begin
            for (int i = 0; i < N; i++) if (stag[i]) s = i;
            foreach (outq[j]) if (outq[j] == s) k = j;
        end
        if (acc && miss) begin
            yng = '0;
            for (int j = k + 1; j < outq.size(); j++) yng[outq[j]] = 1'b1;
            while (outq.size() > k) void'(outq.pop_back());
            ptr = (s + N - 1) % N;
            mpc = pc;
            kill_q.push_back('{mask: yng, pc: pc});
            free_q.push_back(stag);
            n_miss++;
        end else if (acc && succ) begin
            outq.delete(k);
            free_q.push_back(stag);
            n_succ++;
        end
        if (g) begin
            outq.push_back(ptr);
            ptr = (ptr + N - 1) % N;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        alloc_req = 0; prsuccess = 0; prmiss = 0; spectag = '0; tagregfix = '0; jmpaddr = '0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        outq.delete();
        ptr = 0;
        mpc = '0;
        n_succ = 0;
        n_miss = 0;
    endtask

    task automatic expect_now(string nm, logic [N-1:0] km, logic [N-1:0] fm, logic [AW-1:0] pc,
                              logic [N-1:0] bv, logic [N-1:0] at);
        @(negedge clk);
        #1;
        chk({nm, "_kill_mask"}, kill_mask, km);
        chk({nm, "_free_mask"}, free_mask, fm);
        chk({nm, "_redirect_pc"}, redirect_pc, pc);
        chk({nm, "_busy_vec"}, busy_vec, bv);
        chk({nm, "_alloc_tag"}, alloc_tag, at);
    endtask

    function automatic logic [N-1:0] pick_tag();
        int r = $urandom_range(0, 19);
        if (r == 0) return N'($urandom_range(0, 31));
        if (r < 16 && outq.size() > 0) return N'(1) << outq[$urandom_range(0, outq.size() - 1)];
        return N'(1) << $urandom_range(0, N - 1);
    endfunction

    // Monitor: compare per-cycle state and pop expected events whenever the DUT presents them.
    rec_t  mon_r;
    kill_t mon_k;
    always @(negedge clk) begin
        if (mon_en) begin
            if (st_q.size() > 0) begin
                mon_r = st_q.pop_front();
                chk("busy_vec", busy_vec, mon_r.busy);
                chk("full", full, mon_r.full);
                chk("count", count, mon_r.count);
                chk("alloc_gnt", alloc_gnt, mon_r.gnt);
                chk("alloc_tag_state", alloc_tag, mon_r.tag);
                chk("redirect_pc_hold", redirect_pc, mon_r.pc);
            end
            if (alloc_gnt) begin
                if (tag_q.size() == 0) chk("grant_unexpected", 1, 0);
                else chk("grant_tag", alloc_tag, tag_q.pop_front());
            end
            if (kill_valid) begin
                if (kill_q.size() == 0) chk("kill_unexpected", 1, 0);
                else begin
                    mon_k = kill_q.pop_front();
                    chk("kill_mask", kill_mask, mon_k.mask);
                    chk("redirect_pc", redirect_pc, mon_k.pc);
                    chk("redirect_valid", redirect_valid, 1);
                end
            end else begin
                chk("kill_mask_idle", kill_mask, 0);
                chk("redirect_valid_idle", redirect_valid, 0);
            end
            if (free_mask != '0) begin
                if (free_q.size() == 0) chk("free_unexpected", free_mask, 0);
                else chk("free_mask", free_mask, free_q.pop_front());
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        alloc_req = 0; prsuccess = 0; prmiss = 0; spectag = '0; tagregfix = '0; jmpaddr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy_vec", busy_vec, 0);
        chk("rst_alloc_tag", alloc_tag, 5'b00001);
        chk("rst_kill_valid", kill_valid, 0);
        chk("rst_redirect_valid", redirect_valid, 0);
        chk("rst_kill_mask", kill_mask, 0);
        chk("rst_free_mask", free_mask, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        reset = 1'b1;
        mon_en = 1'b1;

        // Fill the ring, try a sixth allocation, then miss with a wrapping younger walk.
        repeat (5) cycle(1, 0, 0, '0, '0);
        cycle(1, 0, 0, '0, '0);
        @(negedge clk);
        #1;
        chk("full_ring_full", full, 1);
        chk("full_ring_count", count, 5);
        chk("full_ring_gnt", alloc_gnt, 0);
        chk("full_ring_busy", busy_vec, 5'b11111);
        cycle(0, 0, 1, 5'b00100, 32'h55);
        cycle(0, 0, 0, '0, '0);
        expect_now("wrap_miss", 5'b00010, 5'b00100, 32'h55, 5'b11001, 5'b00010);

        do_reset();
        repeat (3) cycle(1, 0, 0, '0, '0);
        cycle(0, 0, 1, 5'b10000, 32'h200);
        cycle(0, 0, 0, '0, '0);
        expect_now("miss_mid", 5'b01000, 5'b10000, 32'h200, 5'b00001, 5'b01000);

        do_reset();
        repeat (2) cycle(1, 0, 0, '0, '0);
        cycle(1, 1, 0, 5'b00001, '0);
        cycle(0, 0, 0, '0, '0);
        expect_now("succ_alloc", 5'b00000, 5'b00001, 32'h0, 5'b11000, 5'b00100);

        do_reset();
        cycle(1, 0, 0, '0, '0);
        cycle(1, 0, 1, 5'b00100, 32'h77);
        cycle(0, 0, 0, '0, '0);
        expect_now("miss_idle_tag", 5'b00000, 5'b00000, 32'h0, 5'b00001, 5'b10000);

        // Randomised traffic with a mid-run reset.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int r;
            logic q;
            if (c == 1500) do_reset();
            q = ($urandom_range(0, 9) < 6);
            r = $urandom_range(0, 9);
            cycle(q, (r < 3) || (r == 5), (r == 3) || (r == 4) || (r == 5), pick_tag(), $urandom);
        end
        repeat (3) cycle(0, 0, 0, '0, '0);
        @(negedge clk);
        #1;
        chk("drain_state", st_q.size(), 0);
        chk("drain_grant", tag_q.size(), 0);
        chk("drain_kill", kill_q.size(), 0);
        chk("drain_free", free_q.size(), 0);
`ifdef BRTAG_STATS_EN
        chk("stat_succ", stat_succ, n_succ);
        chk("stat_miss", stat_miss, n_miss);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
